// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encodings, op codes
// and default geometry.
package mem_responder_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_responder_array.sv
// Word-addressed storage: synchronous write-enable port, combinational read port.
module mem_responder_array #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_reg [2**ADDR_W];

    // Contents are deliberately never reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
    end

    assign rdata = mem_reg[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a Read/Write request, waits LATENCY cycles,
// then commits the write or loads Mdatain and pulses Done for one cycle.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [31:0]       MAR_q,
    input  logic [DATA_W-1:0] MDR_q,
    output logic [DATA_W-1:0] Mdatain,
    output logic              Done,
    output logic              Busy,
    output logic              Err
);

    localparam logic [3:0] LAT_LOAD = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

    logic [1:0]        state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              op_reg, op_next;
    logic [DATA_W-1:0] mdat_reg, mdat_next;
    logic              done_reg, busy_reg, err_reg;
    logic              err_next;

    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              acc_op;
    logic              enter_resp;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_mar;

    assign unused_mar = ^MAR_q[31:ADDR_W];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        op_next    = op_reg;
        err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (Read ^ Write) begin
                    addr_next = MAR_q[ADDR_W-1:0];
                    data_next = MDR_q;
                    op_next   = Write ? OP_WRITE : OP_READ;
                    if (LATENCY == 0) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = LAT_LOAD;
                    end
                end else if (Read && Write) begin
                    err_next = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                state_next = ST_RELEASE;
            end
            default: begin
                // Requester must drop both strobes before another access starts.
                if (!Read && !Write) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    // With zero latency the access happens on the request edge itself, so the
    // live inputs are used instead of the (not yet loaded) latches.
    assign acc_addr   = (state_reg == ST_IDLE) ? MAR_q[ADDR_W-1:0] : addr_reg;
    assign acc_data   = (state_reg == ST_IDLE) ? MDR_q : data_reg;
    assign acc_op     = (state_reg == ST_IDLE) ? op_next : op_reg;
    assign enter_resp = (state_next == ST_RESP) && (state_reg != ST_RESP);
    assign mem_we     = enter_resp && (acc_op == OP_WRITE) && !clear;
    assign mdat_next  = (enter_resp && acc_op == OP_READ) ? mem_rdata : mdat_reg;

    mem_responder_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .addr  (acc_addr),
        .wdata (acc_data),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= '0;
            data_reg  <= '0;
            op_reg    <= OP_READ;
            mdat_reg  <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            op_reg    <= op_next;
            mdat_reg  <= mdat_next;
            done_reg  <= (state_next == ST_RESP);
            busy_reg  <= (state_next != ST_IDLE);
            err_reg   <= err_next;
        end
    end

    assign Mdatain = mdat_reg;
    assign Done    = done_reg;
    assign Busy    = busy_reg;
    assign Err     = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected Done/Err events,
// per-instance monitors pop and compare them (cycle, kind, read data).
module tb_mem_responder;

    localparam int K_READ  = 0;
    localparam int K_WRITE = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        a_read = 1'b0, a_write = 1'b0;
    logic [31:0] a_mar = '0, a_mdr = '0;
    logic [31:0] a_mdat;
    logic        a_done, a_busy, a_err;
    logic        b_read = 1'b0, b_write = 1'b0;
    logic [31:0] b_mar = '0, b_mdr = '0;
    logic [31:0] b_mdat;
    logic        b_done, b_busy, b_err;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mem_responder #(.ADDR_W(9), .DATA_W(32), .LATENCY(2)) dut_a (
        .clock(clock), .clear(clear), .Read(a_read), .Write(a_write),
        .MAR_q(a_mar), .MDR_q(a_mdr), .Mdatain(a_mdat), .Done(a_done),
        .Busy(a_busy), .Err(a_err)
    );

    mem_responder #(.ADDR_W(9), .DATA_W(32), .LATENCY(0)) dut_b (
        .clock(clock), .clear(clear), .Read(b_read), .Write(b_write),
        .MAR_q(b_mar), .MDR_q(b_mdr), .Mdatain(b_mdat), .Done(b_done),
        .Busy(b_busy), .Err(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic compare_evt(input string who, input exp_t e, input logic done,
                               input logic err, input logic [31:0] mdat);
        chk({who, "_event_cycle"}, cyc, e.cyc);
        chk({who, "_done"}, {31'd0, done}, {31'd0, e.kind != K_ERR});
        chk({who, "_err"}, {31'd0, err}, {31'd0, e.kind == K_ERR});
        if (e.kind == K_READ) chk({who, "_rdata"}, mdat, e.data);
        $display("[TB] %s kind=%0d cyc=%0d done=%0b err=%0b mdatain=0x%08h",
                 who, e.kind, cyc, done, err, mdat);
    endtask

    always @(negedge clock) begin
        if (!clear && (a_done || a_err)) begin
            if (sb_a.size() == 0) begin
                tests++; fails++;
                $display("FAIL A_unexpected_event: done=%0b err=%0b at cyc %0d, expected none",
                         a_done, a_err, cyc);
            end else begin
                compare_evt("A", sb_a.pop_front(), a_done, a_err, a_mdat);
            end
        end
    end

    always @(negedge clock) begin
        if (!clear && (b_done || b_err)) begin
            if (sb_b.size() == 0) begin
                tests++; fails++;
                $display("FAIL B_unexpected_event: done=%0b err=%0b at cyc %0d, expected none",
                         b_done, b_err, cyc);
            end else begin
                compare_evt("B", sb_b.pop_front(), b_done, b_err, b_mdat);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called just after a clock edge; the next edge is the request edge E0.
    task automatic issue_a(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_rd, input bit push);
        if (push) sb_a.push_back('{kind: (wr ? K_WRITE : K_READ), data: exp_rd, cyc: cyc + 1 + 2});
        a_read = rd; a_write = wr; a_mar = addr; a_mdr = data;
    endtask

    task automatic issue_b(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_rd);
        sb_b.push_back('{kind: (wr ? K_WRITE : K_READ), data: exp_rd, cyc: cyc + 1});
        b_read = rd; b_write = wr; b_mar = addr; b_mdr = data;
    endtask

    task automatic wait_done_a(input string name);
        int n = 0;
        step(1);
        while (!a_done && n < 20) begin
            step(1);
            n++;
        end
        if (!a_done) begin
            tests++; fails++;
            $display("FAIL %s_timeout: Done=0 after %0d cycles, expected Done=1", name, n);
        end
    endtask

    task automatic wait_done_b(input string name);
        int n = 0;
        step(1);
        while (!b_done && n < 20) begin
            step(1);
            n++;
        end
        if (!b_done) begin
            tests++; fails++;
            $display("FAIL %s_timeout: Done=0 after %0d cycles, expected Done=1", name, n);
        end
    endtask

    task automatic full_access_a(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] exp_rd, input string name);
        issue_a(rd, wr, addr, data, exp_rd, 1'b1);
        wait_done_a(name);
        a_read = 1'b0; a_write = 1'b0;
        step(2);
    endtask

    initial begin
        // Reset state
        step(3);
        chk("reset_done", {31'd0, a_done}, 32'd0);
        chk("reset_busy", {31'd0, a_busy}, 32'd0);
        chk("reset_err", {31'd0, a_err}, 32'd0);
        chk("reset_mdatain", a_mdat, 32'd0);
        chk("reset_b_busy", {31'd0, b_busy}, 32'd0);
        clear = 1'b0;
        step(1);

        // 1: write with latency 2, Busy right after E0
        issue_a(1'b0, 1'b1, 32'h0000_0010, 32'h112B_0000, 32'd0, 1'b1);
        step(1);
        chk("t1_busy_after_e0", {31'd0, a_busy}, 32'd1);
        chk("t1_done_after_e0", {31'd0, a_done}, 32'd0);
        while (!a_done && a_busy) step(1);
        chk("t1_done_seen", {31'd0, a_done}, 32'd1);
        a_write = 1'b0;
        step(2);

        // 2: read it back; Mdatain holds after Done
        full_access_a(1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'h112B_0000, "t2");
        step(3);
        chk("t2_mdatain_hold", a_mdat, 32'h112B_0000);

        // 3: both strobes in IDLE -> Err pulse, no access
        sb_a.push_back('{kind: K_ERR, data: 32'd0, cyc: cyc + 1});
        a_read = 1'b1; a_write = 1'b1; a_mdr = 32'hFFFF_FFFF;
        step(1);
        chk("t3_busy", {31'd0, a_busy}, 32'd0);
        a_read = 1'b0; a_write = 1'b0;
        step(1);
        chk("t3_err_cleared", {31'd0, a_err}, 32'd0);

        // 4: Read held past Done -> single Done, then drop/reassert -> second Done
        issue_a(1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'h112B_0000, 1'b1);
        wait_done_a("t4a");
        step(6);
        chk("t4_busy_in_release", {31'd0, a_busy}, 32'd1);
        a_read = 1'b0;
        step(1);
        chk("t4_busy_after_drop", {31'd0, a_busy}, 32'd0);
        full_access_a(1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'h112B_0000, "t4b");

        // 5: write aborted by clear on the commit edge
        full_access_a(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0045, 32'd0, "t5_init");
        issue_a(1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'd0, 1'b0);
        step(2);
        clear = 1'b1;
        step(1);
        chk("t5_busy_cleared", {31'd0, a_busy}, 32'd0);
        chk("t5_done_cleared", {31'd0, a_done}, 32'd0);
        chk("t5_mdatain_cleared", a_mdat, 32'd0);
        clear = 1'b0; a_write = 1'b0;
        step(4);
        full_access_a(1'b1, 1'b0, 32'h0000_0020, 32'd0, 32'h0000_0045, "t5_read");

        // 6: zero-latency instance, upper address bits ignored
        issue_b(1'b0, 1'b1, 32'h0000_01FF, 32'h0000_0034, 32'd0);
        wait_done_b("t6_write");
        b_write = 1'b0;
        step(2);
        issue_b(1'b1, 1'b0, 32'hFFFF_E1FF, 32'd0, 32'h0000_0034);
        wait_done_b("t6_read");
        b_read = 1'b0;
        step(3);
        chk("t6_mdatain_hold", b_mdat, 32'h0000_0034);

        step(2);
        chk("sb_a_drained", sb_a.size(), 32'd0);
        chk("sb_b_drained", sb_b.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
